// File: rtl/first_counter.sv
// Free-running WIDTH-bit up-counter with synchronous clear and count-enable.
// counter_out is the state register itself, so there is no input-to-output combinational path.
module first_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic [WIDTH-1:0] counter_out
);

  logic [WIDTH-1:0] counter_q;
  logic [WIDTH-1:0] counter_d;

  // Priority: clear beats enable, and enable beats hold. The add wraps modulo 2^WIDTH.
  always_comb begin
    counter_d = counter_q;
    if (reset) begin
      counter_d = '0;
    end else if (enable) begin
      counter_d = counter_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    counter_q <= counter_d;
  end

  assign counter_out = counter_q;

endmodule

// File: tb/tb_first_counter.sv
// Directed-vector and randomised check of first_counter against hand-computed values
// and a cycle-level reference model.
module tb_first_counter;
  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             enable = 1'b0;
  logic [WIDTH-1:0] counter_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic             rst;
    logic             en;
    logic [WIDTH-1:0] exp;
  } vec_t;

  vec_t vecs[$];
  logic [WIDTH-1:0] model_q;

  always #5 clk = ~clk;

  first_counter #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .counter_out (counter_out)
  );

  function automatic void add(input logic r, input logic e, input int exp);
    vec_t v;
    v.rst = r;
    v.en  = e;
    v.exp = exp[WIDTH-1:0];
    vecs.push_back(v);
  endfunction

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic apply(input logic r, input logic e, input logic [WIDTH-1:0] exp,
                       input string name);
    @(negedge clk);
    reset  = r;
    enable = e;
    @(posedge clk);
    #1;
    checks++;
    if (counter_out !== exp) begin
      errors++;
      $display("FAIL %s: reset=%0b enable=%0b counter_out=%0d expected %0d",
               name, r, e, counter_out, exp);
    end else begin
      $display("ok   %s: reset=%0b enable=%0b counter_out=%0d", name, r, e, counter_out);
    end
  endtask

  initial begin
    // Reset then count 1..10, then hold at 10.
    add(1, 0, 0);
    for (int i = 1; i <= 10; i++) add(0, 1, i);
    for (int i = 0; i < 3; i++) add(0, 0, 10);
    // Hold at 0 after reset.
    add(1, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 0, 0);
    // Wrap-around: 17 enables give 1..15, 0, 1.
    add(1, 0, 0);
    for (int i = 0; i < 17; i++) add(0, 1, (i + 1) % 16);
    // Reset priority over enable at 7.
    add(1, 0, 0);
    for (int i = 1; i <= 7; i++) add(0, 1, i);
    add(1, 1, 0);
    for (int i = 1; i <= 3; i++) add(0, 1, i);

    foreach (vecs[i]) apply(vecs[i].rst, vecs[i].en, vecs[i].exp, "table");

    // Mid-count reset held for three cycles with enable high.
    apply(1, 0, 4'd0, "mid_rst");
    apply(0, 1, 4'd1, "mid_cnt");
    apply(0, 1, 4'd2, "mid_cnt");
    apply(0, 1, 4'd3, "mid_cnt");
    apply(0, 1, 4'd4, "mid_cnt");
    apply(0, 1, 4'd5, "mid_cnt");
    apply(1, 1, 4'd0, "mid_hold_rst");
    apply(1, 1, 4'd0, "mid_hold_rst");
    apply(1, 1, 4'd0, "mid_hold_rst");
    apply(0, 1, 4'd1, "mid_resume");
    apply(0, 1, 4'd2, "mid_resume");
    apply(0, 1, 4'd3, "mid_resume");

    // Random reset/enable against the reference model; the count is already known to be 3.
    model_q = 4'd3;
    for (int i = 0; i < 200; i++) begin
      logic r;
      logic e;
      r = ($urandom_range(0, 9) == 0);
      e = $urandom_range(0, 1) == 1;
      if (r)      model_q = '0;
      else if (e) model_q = model_q + 4'd1;
      apply(r, e, model_q, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
